// File: rtl/rvvi_retire_cmp.sv
// Retirement comparator: buffers DUT and reference retirement packets in two FIFOs and compares heads.
// Optional GPR writeback comparison (wen/rd/wdata) is enabled by defining RVVI_CMP_GPR_EN.
module rvvi_retire_cmp #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_ERRORS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 dut_valid,
  output logic                 dut_ready,
  input  logic [2*XLEN+102:0]  dut_pkt,
  input  logic                 ref_valid,
  output logic                 ref_ready,
  input  logic [2*XLEN+102:0]  ref_pkt,
  output logic                 err_valid,
  output logic [5:0]           err_code,
  output logic [63:0]          err_order,
  output logic [15:0]          err_count,
  output logic [31:0]          match_count,
  output logic                 halt
);

  localparam int unsigned PW = 2 * XLEN + 103;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FullXor = {1'b1, {AW{1'b0}}};

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e state_q, state_d;

  logic [PW-1:0] dut_mem [DEPTH];
  logic [PW-1:0] ref_mem [DEPTH];
  logic [AW:0]   wp_q [2];
  logic [AW:0]   rp_q [2];
  logic [1:0]    in_valid, full, empty, push;
  logic          pop;
  logic [PW-1:0] dut_head, ref_head;
  logic [5:0]    mask;

  logic          err_valid_q;
  logic [5:0]    err_code_q;
  logic [63:0]   err_order_q;
  logic [15:0]   err_count_q;
  logic [31:0]   match_count_q;

  assign in_valid = {ref_valid, dut_valid};

  // Index 0 is the DUT side, index 1 the reference side.
  always_comb begin
    full  = '0;
    empty = '0;
    push  = '0;
    for (int s = 0; s < 2; s++) begin
      full[s]  = (wp_q[s] ^ rp_q[s]) == FullXor;
      empty[s] = wp_q[s] == rp_q[s];
      push[s]  = in_valid[s] && !full[s] && (state_q == StRun) && !clear;
    end
  end

  assign pop       = !empty[0] && !empty[1] && (state_q == StRun) && !clear;
  assign dut_ready = !full[0] && !halt;
  assign ref_ready = !full[1] && !halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        wp_q[s] <= '0;
        rp_q[s] <= '0;
      end
    end else if (clear) begin
      for (int s = 0; s < 2; s++) begin
        wp_q[s] <= '0;
        rp_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wp_q[s] <= wp_q[s] + PtrOne;
        if (pop)     rp_q[s] <= rp_q[s] + PtrOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push[0]) dut_mem[wp_q[0][AW-1:0]] <= dut_pkt;
    if (push[1]) ref_mem[wp_q[1][AW-1:0]] <= ref_pkt;
  end

  assign dut_head = dut_mem[rp_q[0][AW-1:0]];
  assign ref_head = ref_mem[rp_q[1][AW-1:0]];

  always_comb begin
    mask    = '0;
    mask[0] = dut_head[PW-1 -: 64] != ref_head[PW-1 -: 64];
    mask[1] = dut_head[PW-65 -: XLEN] != ref_head[PW-65 -: XLEN];
    mask[2] = dut_head[XLEN+38 -: 32] != ref_head[XLEN+38 -: 32];
    mask[3] = dut_head[XLEN+6] != ref_head[XLEN+6];
`ifdef RVVI_CMP_GPR_EN
    mask[4] = (dut_head[XLEN+5] != ref_head[XLEN+5]) ||
              (dut_head[XLEN+5] && ref_head[XLEN+5] &&
               (dut_head[XLEN+4 -: 5] != ref_head[XLEN+4 -: 5]));
    mask[5] = dut_head[XLEN+5] && ref_head[XLEN+5] &&
              (dut_head[XLEN-1:0] != ref_head[XLEN-1:0]);
`endif
  end

`ifndef RVVI_CMP_GPR_EN
  logic unused_gpr;
  assign unused_gpr = ^{dut_head[XLEN+5:0], ref_head[XLEN+5:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q   <= 1'b0;
      err_code_q    <= '0;
      err_order_q   <= '0;
      err_count_q   <= '0;
      match_count_q <= '0;
    end else if (clear) begin
      err_valid_q   <= 1'b0;
      err_count_q   <= '0;
      match_count_q <= '0;
    end else begin
      err_valid_q <= pop && (mask != '0);
      if (pop && (mask != '0)) begin
        err_code_q  <= mask;
        err_order_q <= dut_head[PW-1 -: 64];
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      end else if (pop) begin
        match_count_q <= match_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StRun;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun:  if ((MAX_ERRORS != 0) && (err_count_q == 16'(MAX_ERRORS))) state_d = StHalt;
        StHalt: state_d = StHalt;
      endcase
    end
  end

  always_comb begin
    halt = (state_q == StHalt);
  end

  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign err_order   = err_order_q;
  assign err_count   = err_count_q;
  assign match_count = match_count_q;

endmodule
